regf_wb_queue: RTL

//  Writeback queue and write-port driver for the register file (mem_regf) write port C.

---
 rtl/regf_wb_queue.sv | 132 +++++++++++++
 1 files changed

// File: rtl/regf_wb_queue.sv
// Writeback queue for register-file port C: buffers ALU and load results in order,
// drains one write per cycle, and forwards pending data to read ports A/B.
module regf_wb_queue #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int PW    = 2
) (
   input  logic             clk,
   input  logic             reset_b,
   input  logic             halt,
   input  logic             mem_we,
   input  logic [WIDTH-1:0] mem_addr,
   input  logic [31:0]      mem_data,
   output logic             mem_ready,
   input  logic             alu_we,
   input  logic [WIDTH-1:0] alu_addr,
   input  logic [31:0]      alu_data,
   output logic             alu_ready,
   input  logic [WIDTH-1:0] addra,
   input  logic [WIDTH-1:0] addrb,
   output logic             fwd_a_hit,
   output logic [31:0]      fwd_a,
   output logic             fwd_b_hit,
   output logic [31:0]      fwd_b,
   output logic [WIDTH-1:0] addrc,
   output logic [31:0]      dc,
   output logic             wec,
   output logic [PW:0]      count
);

   localparam logic [PW:0] DEPTH_C    = (PW+1)'(DEPTH);
   localparam logic [PW:0] DEPTH_M1_C = (PW+1)'(DEPTH - 1);
   localparam logic [PW:0] DEPTH_M2_C = (PW+1)'(DEPTH - 2);

   logic [WIDTH-1:0] addr_mem_r [DEPTH];
   logic [31:0]      data_mem_r [DEPTH];
   logic [PW-1:0]    head_r;
   logic [PW-1:0]    tail_r;
   logic [PW:0]      count_r;
   logic [WIDTH-1:0] addrc_r;
   logic [31:0]      dc_r;
   logic             wec_r;

   logic             mem_ready_s;
   logic             alu_ready_s;
   logic             acc_mem_s;
   logic             acc_alu_s;
   logic             pop_s;
   logic [PW-1:0]    alu_wptr_s;
   logic [PW:0]      count_next_s;
   logic             fwd_a_hit_s;
   logic [31:0]      fwd_a_s;
   logic             fwd_b_hit_s;
   logic [31:0]      fwd_b_s;

   assign mem_ready = mem_ready_s;
   assign alu_ready = alu_ready_s;
   assign fwd_a_hit = fwd_a_hit_s;
   assign fwd_a     = fwd_a_s;
   assign fwd_b_hit = fwd_b_hit_s;
   assign fwd_b     = fwd_b_s;
   assign addrc     = addrc_r;
   assign dc        = dc_r;
   assign wec       = wec_r;
   assign count     = count_r;

   // Ready, acceptance, pop decision and next occupancy
   always_comb begin
      mem_ready_s  = (count_r < DEPTH_C);
      // alu is the second slot when both producers push, so it needs two free entries
      alu_ready_s  = (count_r <= DEPTH_M2_C) | ((count_r == DEPTH_M1_C) & ~mem_we);
      acc_mem_s    = mem_we & mem_ready_s;
      acc_alu_s    = alu_we & alu_ready_s;
      pop_s        = ~halt & (count_r != {(PW+1){1'b0}});
      alu_wptr_s   = tail_r + PW'(acc_mem_s);
      count_next_s = count_r + (PW+1)'(acc_mem_s) + (PW+1)'(acc_alu_s) - (PW+1)'(pop_s);
   end

   // FIFO storage; entries outside the live window are never read
   always_ff @(posedge clk) begin
      if (acc_mem_s) begin
         addr_mem_r[tail_r] <= mem_addr;
         data_mem_r[tail_r] <= mem_data;
      end
      if (acc_alu_s) begin
         addr_mem_r[alu_wptr_s] <= alu_addr;
         data_mem_r[alu_wptr_s] <= alu_data;
      end
   end

   // Pointers, occupancy and the registered write port
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         head_r  <= {PW{1'b0}};
         tail_r  <= {PW{1'b0}};
         count_r <= {(PW+1){1'b0}};
         addrc_r <= {WIDTH{1'b0}};
         dc_r    <= 32'd0;
         wec_r   <= 1'b0;
      end else begin
         tail_r  <= tail_r + PW'(acc_mem_s) + PW'(acc_alu_s);
         count_r <= count_next_s;
         if (pop_s) begin
            head_r  <= head_r + PW'(1'b1);
            addrc_r <= addr_mem_r[head_r];
            dc_r    <= data_mem_r[head_r];
            wec_r   <= 1'b1;
         end else begin
            wec_r   <= 1'b0;
         end
      end
   end

   // Forwarding: scan oldest to newest so the newest match overrides older ones
   always_comb begin
      fwd_a_hit_s = wec_r & (addrc_r == addra);
      fwd_a_s     = (wec_r & (addrc_r == addra)) ? dc_r : 32'd0;
      fwd_b_hit_s = wec_r & (addrc_r == addrb);
      fwd_b_s     = (wec_r & (addrc_r == addrb)) ? dc_r : 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_a_s     = (((PW+1)'(i) < count_r) && (addr_mem_r[head_r + PW'(i)] == addra))
                       ? data_mem_r[head_r + PW'(i)] : fwd_a_s;
         fwd_a_hit_s = (((PW+1)'(i) < count_r) && (addr_mem_r[head_r + PW'(i)] == addra))
                       ? 1'b1 : fwd_a_hit_s;
         fwd_b_s     = (((PW+1)'(i) < count_r) && (addr_mem_r[head_r + PW'(i)] == addrb))
                       ? data_mem_r[head_r + PW'(i)] : fwd_b_s;
         fwd_b_hit_s = (((PW+1)'(i) < count_r) && (addr_mem_r[head_r + PW'(i)] == addrb))
                       ? 1'b1 : fwd_b_hit_s;
      end
   end

endmodule
